// File: rtl/sc_comp.sv
// Single-cycle MIPS-subset computer: CPU core, instruction ROM and data RAM.
// One instruction retires per rising clk edge; rstn is a synchronous active-high reset.

module sc_im #(
    parameter int IM_DEPTH = 256
) (
    input  logic [31:0] addr_i,
    output logic [31:0] instr_o
);
    localparam int AW = $clog2(IM_DEPTH);

    logic [31:0] ROM [0:IM_DEPTH-1];
    logic        unused_lsb;

    assign unused_lsb = ^addr_i[1:0];
    // Anything past the end of the ROM decodes as a nop.
    assign instr_o = (addr_i >= 32'(IM_DEPTH * 4)) ? 32'h0 : ROM[addr_i[AW+1:2]];
endmodule

module sc_dm #(
    parameter int DM_DEPTH = 128
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wd_i,
    output logic [31:0] rd_o
);
    localparam int AW = $clog2(DM_DEPTH);

    logic [31:0] RAM [0:DM_DEPTH-1];
    logic        unused_addr;

    assign unused_addr = ^{addr_i[31:AW+2], addr_i[1:0]};
    assign rd_o = RAM[addr_i[AW+1:2]];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DM_DEPTH; i++) RAM[i] <= '0;
        end else if (we_i) begin
            RAM[addr_i[AW+1:2]] <= wd_i;
        end
    end
endmodule

module sc_rf (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        we_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i,
    input  logic [4:0]  ra1_i,
    input  logic [4:0]  ra2_i,
    input  logic [4:0]  ra3_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o,
    output logic [31:0] rd3_o
);
    logic [31:0] rf [0:31];

    assign rd1_o = (ra1_i == 5'd0) ? 32'h0 : rf[ra1_i];
    assign rd2_o = (ra2_i == 5'd0) ? 32'h0 : rf[ra2_i];
    assign rd3_o = (ra3_i == 5'd0) ? 32'h0 : rf[ra3_i];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (we_i && wa_i != 5'd0) begin
            rf[wa_i] <= wd_i;
        end
    end
endmodule

module sc_cpu (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] dm_rd_i,
    input  logic [4:0]  dbg_sel_i,
    output logic [31:0] pc_o,
    output logic        dm_we_o,
    output logic [31:0] dm_addr_o,
    output logic [31:0] dm_wd_o,
    output logic [31:0] dbg_data_o
);
    logic [31:0] PC_out;
    logic [31:0] pc_d, pc4;
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt, wa;
    logic [31:0] rs_v, rt_v, imm_s, imm_z, wd;
    logic        rf_we;

    assign op    = instr_i[31:26];
    assign rs    = instr_i[25:21];
    assign rt    = instr_i[20:16];
    assign rd    = instr_i[15:11];
    assign shamt = instr_i[10:6];
    assign funct = instr_i[5:0];
    assign imm_s = {{16{instr_i[15]}}, instr_i[15:0]};
    assign imm_z = {16'h0, instr_i[15:0]};
    assign pc4   = PC_out + 32'd4;

    assign pc_o      = PC_out;
    assign dm_addr_o = rs_v + imm_s;
    assign dm_wd_o   = rt_v;

    sc_rf U_RF (
        .clk_i(clk_i), .rst_i(rst_i),
        .we_i(rf_we), .wa_i(wa), .wd_i(wd),
        .ra1_i(rs), .ra2_i(rt), .ra3_i(dbg_sel_i),
        .rd1_o(rs_v), .rd2_o(rt_v), .rd3_o(dbg_data_o)
    );

    always_comb begin
        pc_d    = pc4;
        rf_we   = 1'b0;
        wa      = rt;
        wd      = 32'h0;
        dm_we_o = 1'b0;
        case (op)
            6'h00: begin
                wa    = rd;
                rf_we = 1'b1;
                case (funct)
                    6'h20: wd = rs_v + rt_v;
                    6'h22: wd = rs_v - rt_v;
                    6'h24: wd = rs_v & rt_v;
                    6'h25: wd = rs_v | rt_v;
                    6'h26: wd = rs_v ^ rt_v;
                    6'h27: wd = ~(rs_v | rt_v);
                    6'h2a: wd = {31'h0, $signed(rs_v) < $signed(rt_v)};
                    6'h2b: wd = {31'h0, rs_v < rt_v};
                    6'h00: wd = rt_v << shamt;
                    6'h02: wd = rt_v >> shamt;
                    6'h03: wd = $signed(rt_v) >>> shamt;
                    6'h08: begin rf_we = 1'b0; pc_d = rs_v; end
                    6'h09: begin wd = pc4; pc_d = rs_v; end
                    default: rf_we = 1'b0;
                endcase
            end
            6'h08: begin rf_we = 1'b1; wd = rs_v + imm_s; end
            6'h0c: begin rf_we = 1'b1; wd = rs_v & imm_z; end
            6'h0d: begin rf_we = 1'b1; wd = rs_v | imm_z; end
            6'h0e: begin rf_we = 1'b1; wd = rs_v ^ imm_z; end
            6'h0a: begin rf_we = 1'b1; wd = {31'h0, $signed(rs_v) < $signed(imm_s)}; end
            6'h0f: begin rf_we = 1'b1; wd = {instr_i[15:0], 16'h0}; end
            6'h23: begin rf_we = 1'b1; wd = dm_rd_i; end
            6'h2b: dm_we_o = 1'b1;
            6'h04: if (rs_v == rt_v) pc_d = pc4 + (imm_s << 2);
            6'h05: if (rs_v != rt_v) pc_d = pc4 + (imm_s << 2);
            6'h02: pc_d = {pc4[31:28], instr_i[25:0], 2'b00};
            6'h03: begin
                pc_d  = {pc4[31:28], instr_i[25:0], 2'b00};
                rf_we = 1'b1;
                wa    = 5'd31;
                wd    = pc4;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) PC_out <= 32'h0;
        else       PC_out <= pc_d;
    end
endmodule

module sc_comp #(
    parameter int IM_DEPTH = 256,
    parameter int DM_DEPTH = 128
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [4:0]  reg_sel,
    output logic [31:0] reg_data
);
    logic [31:0] PC, instr;
    logic [31:0] dm_addr, dm_wd, dm_rd;
    logic        dm_we;

    sc_im #(.IM_DEPTH(IM_DEPTH)) U_IM (
        .addr_i(PC), .instr_o(instr)
    );

    sc_cpu U_SCPU (
        .clk_i(clk), .rst_i(rstn),
        .instr_i(instr), .dm_rd_i(dm_rd), .dbg_sel_i(reg_sel),
        .pc_o(PC), .dm_we_o(dm_we), .dm_addr_o(dm_addr),
        .dm_wd_o(dm_wd), .dbg_data_o(reg_data)
    );

    sc_dm #(.DM_DEPTH(DM_DEPTH)) U_DM (
        .clk_i(clk), .rst_i(rstn), .we_i(dm_we),
        .addr_i(dm_addr), .wd_i(dm_wd), .rd_o(dm_rd)
    );
endmodule

// File: tb/tb_sc_comp.sv
// Directed-program bench for sc_comp: loads ROM by hierarchy, runs short
// programs and compares architectural state to hand-computed values.

module tb_sc_comp;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [4:0]  reg_sel = 5'd0;
    logic [31:0] reg_data;

    int pass_cnt = 0;
    int total = 0;

    sc_comp dut (.clk(clk), .rstn(rstn), .reg_sel(reg_sel), .reg_data(reg_data));

    always #5 clk = ~clk;

    function automatic logic [31:0] R(input int rs, input int rt, input int rd,
                                      input int sh, input int fn);
        return {6'h0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] I(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] J(input int op, input int tgt);
        return {6'(op), 26'(tgt)};
    endfunction

    task automatic load(input logic [31:0] prog[$]);
        for (int i = 0; i < 256; i++) dut.U_IM.ROM[i] = 32'h0;
        foreach (prog[i]) dut.U_IM.ROM[i] = prog[i];
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b1;
        step(1);
        rstn = 1'b0;
    endtask

    function automatic logic [31:0] alu_prog_word0();
        return I(8, 0, 1, 5);
    endfunction

    task automatic test_reset();
        logic [31:0] p[$];
        p = {I(8, 0, 1, 5), I(8, 0, 2, -3)};
        load(p);
        step(1);
        do_reset();
        total++;
        if (dut.PC !== 32'h0) $display("FAIL reset_pc got %h want %h", dut.PC, 32'h0);
        else pass_cnt++;
        total++;
        if (dut.instr !== 32'h20010005) $display("FAIL reset_instr got %h want %h", dut.instr, 32'h20010005);
        else pass_cnt++;
        for (int s = 0; s < 32; s++) begin
            reg_sel = 5'(s);
            #1;
            total++;
            if (reg_data !== 32'h0) $display("FAIL reset_reg_data sel %0d got %h want 0", s, reg_data);
            else pass_cnt++;
        end
        reg_sel = 5'd0;
    endtask

    task automatic test_alu();
        logic [31:0] p[$];
        logic [31:0] exp_v [1:13];
        p = {I(8, 0, 1, 5), I(8, 0, 2, -3),
             R(1, 2, 3, 0, 'h20), R(1, 2, 4, 0, 'h22), R(2, 1, 5, 0, 'h2a),
             R(1, 2, 6, 0, 'h24), R(1, 2, 7, 0, 'h25), R(1, 2, 8, 0, 'h26),
             R(1, 2, 9, 0, 'h27), R(2, 1, 10, 0, 'h2b), R(0, 2, 11, 4, 'h00),
             R(0, 2, 12, 28, 'h02), R(0, 2, 13, 1, 'h03)};
        exp_v = '{32'h5, 32'hFFFFFFFD, 32'h2, 32'h8, 32'h1,
                  32'h5, 32'hFFFFFFFD, 32'hFFFFFFF8, 32'h2, 32'h0,
                  32'hFFFFFFD0, 32'h0000000F, 32'hFFFFFFFE};
        load(p);
        do_reset();
        step(13);
        for (int r = 1; r <= 13; r++) begin
            total++;
            if (dut.U_SCPU.U_RF.rf[r] !== exp_v[r])
                $display("FAIL alu_rf%0d got %h want %h", r, dut.U_SCPU.U_RF.rf[r], exp_v[r]);
            else pass_cnt++;
        end
        reg_sel = 5'd4;
        #1;
        total++;
        if (reg_data !== 32'h8) $display("FAIL alu_reg_data4 got %h want %h", reg_data, 32'h8);
        else pass_cnt++;
        total++;
        if (dut.PC !== 32'd52) $display("FAIL alu_pc got %h want %h", dut.PC, 32'd52);
        else pass_cnt++;
    endtask

    task automatic test_mem();
        logic [31:0] p[$];
        logic [31:0] exp_v [6:14];
        p = {I('h0f, 0, 6, 'h1234), I('h0d, 6, 6, 'h5678), I('h2b, 0, 6, 8),
             I('h23, 0, 7, 8), I(8, 0, 8, 16), I('h23, 8, 9, -8),
             I('h0c, 6, 10, 'hFFFF), I('h0e, 0, 11, 'h8000), I('h0a, 0, 12, -1),
             I('h0a, 0, 13, 1), I(8, 0, 14, 'h8000)};
        exp_v = '{32'h12345678, 32'h12345678, 32'h10, 32'h12345678,
                  32'h5678, 32'h8000, 32'h0, 32'h1, 32'hFFFF8000};
        load(p);
        do_reset();
        step(11);
        for (int r = 6; r <= 14; r++) begin
            total++;
            if (dut.U_SCPU.U_RF.rf[r] !== exp_v[r])
                $display("FAIL mem_rf%0d got %h want %h", r, dut.U_SCPU.U_RF.rf[r], exp_v[r]);
            else pass_cnt++;
        end
        total++;
        if (dut.U_DM.RAM[2] !== 32'h12345678) $display("FAIL mem_ram2 got %h want %h", dut.U_DM.RAM[2], 32'h12345678);
        else pass_cnt++;
        reg_sel = 5'd7;
        #1;
        total++;
        if (reg_data !== 32'h12345678) $display("FAIL mem_reg_data7 got %h want %h", reg_data, 32'h12345678);
        else pass_cnt++;
    endtask

    task automatic test_branch();
        logic [31:0] p[$];
        p = {I(8, 0, 1, 1), I(4, 1, 1, 1), I(8, 0, 2, 99), I(5, 1, 1, 1),
             I(8, 0, 3, 7), 32'h0, 32'h0, 32'h0,
             J(3, 12), I(8, 0, 4, 4), J(2, 10), 32'h0,
             I(8, 0, 5, 5), R(31, 0, 0, 0, 'h08)};
        load(p);
        do_reset();
        step(8);
        total++;
        if (dut.PC !== 32'h30) $display("FAIL br_jal_pc got %h want %h", dut.PC, 32'h30);
        else pass_cnt++;
        total++;
        if (dut.U_SCPU.U_RF.rf[31] !== 32'h24) $display("FAIL br_jal_link got %h want %h", dut.U_SCPU.U_RF.rf[31], 32'h24);
        else pass_cnt++;
        step(2);
        total++;
        if (dut.PC !== 32'h24) $display("FAIL br_jr_pc got %h want %h", dut.PC, 32'h24);
        else pass_cnt++;
        step(4);
        total++;
        if (dut.PC !== 32'h28) $display("FAIL br_loop_pc got %h want %h", dut.PC, 32'h28);
        else pass_cnt++;
        total++;
        if (dut.U_SCPU.U_RF.rf[2] !== 32'h0) $display("FAIL br_beq_skip got %h want %h", dut.U_SCPU.U_RF.rf[2], 32'h0);
        else pass_cnt++;
        total++;
        if (dut.U_SCPU.U_RF.rf[3] !== 32'h7) $display("FAIL br_bne_fall got %h want %h", dut.U_SCPU.U_RF.rf[3], 32'h7);
        else pass_cnt++;
        total++;
        if (dut.U_SCPU.U_RF.rf[4] !== 32'h4) $display("FAIL br_after_ret got %h want %h", dut.U_SCPU.U_RF.rf[4], 32'h4);
        else pass_cnt++;
        total++;
        if (dut.U_SCPU.U_RF.rf[5] !== 32'h5) $display("FAIL br_callee got %h want %h", dut.U_SCPU.U_RF.rf[5], 32'h5);
        else pass_cnt++;
    endtask

    task automatic test_halt();
        logic [31:0] p[$];
        p = {I(8, 0, 0, 5), I(8, 0, 1, 1), J(2, 'h100)};
        load(p);
        do_reset();
        step(3);
        total++;
        if (dut.PC !== 32'h400) $display("FAIL halt_pc got %h want %h", dut.PC, 32'h400);
        else pass_cnt++;
        step(5);
        total++;
        if (dut.PC !== 32'h414) $display("FAIL halt_nop_pc got %h want %h", dut.PC, 32'h414);
        else pass_cnt++;
        total++;
        if ($isunknown(dut.U_SCPU.PC_out)) $display("FAIL halt_pc_x got %h want known", dut.U_SCPU.PC_out);
        else pass_cnt++;
        total++;
        if (dut.instr !== 32'h0) $display("FAIL halt_instr got %h want %h", dut.instr, 32'h0);
        else pass_cnt++;
        reg_sel = 5'd0;
        #1;
        total++;
        if (dut.U_SCPU.U_RF.rf[0] !== 32'h0 || reg_data !== 32'h0)
            $display("FAIL halt_rf0 got %h/%h want 0", dut.U_SCPU.U_RF.rf[0], reg_data);
        else pass_cnt++;
        total++;
        if (dut.U_SCPU.U_RF.rf[1] !== 32'h1) $display("FAIL halt_rf1 got %h want %h", dut.U_SCPU.U_RF.rf[1], 32'h1);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] p[$];
        p = {I(8, 0, 1, 5), I('h2b, 0, 1, 4), I(8, 0, 2, 6), I(8, 0, 3, 7)};
        load(p);
        do_reset();
        step(3);
        total++;
        if (dut.U_DM.RAM[1] !== 32'h5 || dut.U_SCPU.U_RF.rf[2] !== 32'h6)
            $display("FAIL mid_pre got %h/%h want 5/6", dut.U_DM.RAM[1], dut.U_SCPU.U_RF.rf[2]);
        else pass_cnt++;
        do_reset();
        total++;
        if (dut.PC !== 32'h0) $display("FAIL mid_pc got %h want %h", dut.PC, 32'h0);
        else pass_cnt++;
        total++;
        if (dut.U_SCPU.U_RF.rf[1] !== 32'h0 || dut.U_SCPU.U_RF.rf[2] !== 32'h0 ||
            dut.U_SCPU.U_RF.rf[3] !== 32'h0)
            $display("FAIL mid_rf got %h/%h/%h want 0", dut.U_SCPU.U_RF.rf[1],
                     dut.U_SCPU.U_RF.rf[2], dut.U_SCPU.U_RF.rf[3]);
        else pass_cnt++;
        total++;
        if (dut.U_DM.RAM[1] !== 32'h0) $display("FAIL mid_ram got %h want %h", dut.U_DM.RAM[1], 32'h0);
        else pass_cnt++;
        step(1);
        total++;
        if (dut.PC !== 32'h4 || dut.U_SCPU.U_RF.rf[1] !== 32'h5)
            $display("FAIL mid_restart got %h/%h want 4/5", dut.PC, dut.U_SCPU.U_RF.rf[1]);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mem();
        test_branch();
        test_halt();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
